// File: rtl/data_memory_lsu.sv
// Byte-addressed RV32 data memory with B/H/W loads and stores, sign/zero extension and error reporting.
// Latency: the response appears RD_LAT cycles after the accept edge; one response per request, in order.
// Backpressure: none. req_ready is 1 from the first edge after reset release; one request per cycle.
//
// Ports:
//   clk, rst         clock; asynchronous active-low reset
//   req_valid/ready  request handshake; req_we (1 = store), req_size (funct3), req_addr, req_wdata
//   rsp_valid        response strobe, one cycle per accepted request
//   rsp_rdata        extended load data; 0 for stores, errors and idle cycles
//   rsp_err          illegal size, misaligned access or address out of range
module data_memory_lsu #(
  parameter int    DEPTH_WORDS = 1024,
  parameter int    ADDR_W      = 32,
  parameter int    RD_LAT      = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(4 * DEPTH_WORDS);

  logic [3:0][7:0] mem [DEPTH_WORDS];

  // Word 0 is defined as zero at time zero.
  initial begin
    mem[0] = '0;
  end

  logic             accept;
  logic [IDX_W-1:0] word_idx;
  logic [1:0]       lane;
  logic             req_err;
  logic [31:0]      rd_word;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [31:0]      ld_data;
  logic             wr_en;
  logic [3:0]       wr_be;
  logic [31:0]      wr_lanes;

  logic [RD_LAT-1:0]       pipe_vld;
  logic [RD_LAT-1:0]       pipe_err;
  logic [RD_LAT-1:0][31:0] pipe_dat;

  assign accept   = req_valid & req_ready;
  assign word_idx = req_addr[IDX_W+1:2];
  assign lane     = req_addr[1:0];

  always_comb begin
    req_err = 1'b0;
    // Reserved funct3 encodings.
    if (req_size == 3'b011 || req_size == 3'b110 || req_size == 3'b111) req_err = 1'b1;
    // Unsigned variants exist only for loads.
    if (req_we && req_size[2]) req_err = 1'b1;
    // Half (H/HU) needs even address; word needs 4-byte alignment.
    if (req_size[1:0] == 2'b01 && req_addr[0]) req_err = 1'b1;
    if (req_size == 3'b010 && req_addr[1:0] != 2'b00) req_err = 1'b1;
    if ({1'b0, req_addr} >= MEM_BYTES) req_err = 1'b1;
  end

  // Load path: asynchronous array read, registered into the first pipe stage at the accept edge.
  always_comb begin
    rd_word = mem[word_idx];
    rd_byte = rd_word[8*lane +: 8];
    rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    ld_data = 32'h0;
    case (req_size)
      3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
      3'b010:  ld_data = rd_word;
      3'b100:  ld_data = {24'h0, rd_byte};
      3'b101:  ld_data = {16'h0, rd_half};
      default: ld_data = 32'h0;
    endcase
  end

  // Store path: store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    wr_en    = accept & req_we & ~req_err;
    wr_be    = 4'b1111;
    wr_lanes = req_wdata;
    case (req_size[1:0])
      2'b00: begin
        wr_be    = 4'b0001 << lane;
        wr_lanes = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        wr_be    = lane[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{req_wdata[15:0]}};
      end
      default: begin
        wr_be    = 4'b1111;
        wr_lanes = req_wdata;
      end
    endcase
  end

  // Array is not reset: contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[word_idx][b] <= wr_lanes[8*b +: 8];
      end
    end
  end

  // Response pipe. Data is forced to zero in non-load stages so the output is zero when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_ready <= 1'b0;
      pipe_vld  <= '0;
      pipe_err  <= '0;
      pipe_dat  <= '0;
    end else begin
      req_ready   <= 1'b1;
      pipe_vld[0] <= accept;
      pipe_err[0] <= accept & req_err;
      pipe_dat[0] <= (accept && !req_we && !req_err) ? ld_data : 32'h0;
      for (int s = 1; s < RD_LAT; s++) begin
        pipe_vld[s] <= pipe_vld[s-1];
        pipe_err[s] <= pipe_err[s-1];
        pipe_dat[s] <= pipe_dat[s-1];
      end
    end
  end

  assign rsp_valid = pipe_vld[RD_LAT-1];
  assign rsp_err   = pipe_err[RD_LAT-1];
  assign rsp_rdata = pipe_dat[RD_LAT-1];

endmodule

// File: tb/tb_data_memory_lsu.sv
module tb_data_memory_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_size = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;

  logic        rdy1, rv1, re1;
  logic [31:0] rd1;
  logic        rdy3, rv3, re3;
  logic [31:0] rd3;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic ready_exp = 1'b0;

  typedef struct {
    int          due;
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];

  // Byte-level reference memory covering the 4 KiB address space.
  logic [7:0] mdl [4096];

  data_memory_lsu #(.DEPTH_WORDS(1024), .ADDR_W(32), .RD_LAT(1), .INIT_FILE("")) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(re1));

  data_memory_lsu #(.DEPTH_WORDS(1024), .ADDR_W(32), .RD_LAT(3), .INIT_FILE("")) u3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy3), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(re3));

  // cyc counts falling edges and is updated before clk falls.
  initial begin
    forever begin
      #5 clk = 1'b1;
      #5 cyc++;
      clk = 1'b0;
    end
  end

  task automatic model(input logic we, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] md, output logic me);
    int nb;
    logic [31:0] v;
    me = 1'b0;
    md = 32'h0;
    nb = (sz[1:0] == 2'b00) ? 1 : (sz[1:0] == 2'b01) ? 2 : 4;
    if (sz == 3'b011 || sz == 3'b110 || sz == 3'b111) me = 1'b1;
    if (we && (sz == 3'b100 || sz == 3'b101)) me = 1'b1;
    if ((a % nb) != 0) me = 1'b1;
    if (a >= 32'd4096) me = 1'b1;
    if (!me) begin
      if (we) begin
        for (int i = 0; i < nb; i++) mdl[int'(a) + i] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < nb; i++) v = v | (32'(mdl[int'(a) + i]) << (8*i));
        if (!sz[2] && nb == 1 && v[7]) v = v | 32'hFFFF_FF00;
        if (!sz[2] && nb == 2 && v[15]) v = v | 32'hFFFF_0000;
        md = v;
      end
    end
  endtask

  // Drives one request for one cycle; hx_d/hx_e are the hand-computed results.
  task automatic req(input logic we, input logic [2:0] sz, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] hx_d, input logic hx_e,
                     input string nm);
    logic [31:0] md;
    logic        me;
    exp_t        e;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = sz;
    req_addr  = a;
    req_wdata = wd;
    model(we, sz, a, wd, md, me);
    n_chk++;
    if (md !== hx_d || me !== hx_e) begin
      n_fail++;
      $display("FAIL model_%s got d=%h e=%b exp d=%h e=%b", nm, md, me, hx_d, hx_e);
    end
    e.d = md;
    e.e = me;
    e.due = cyc + 1;
    q1.push_back(e);
    e.due = cyc + 3;
    q3.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      req_we    = 1'b0;
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s got %b exp %b", nm, act, expv);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check1("ready_before_edge_u1", rdy1, 1'b0);
    check1("ready_before_edge_u3", rdy3, 1'b0);
    @(posedge clk);
    #1;
    check1("ready_after_edge_u1", rdy1, 1'b1);
    check1("ready_after_edge_u3", rdy3, 1'b1);
    ready_exp = 1'b1;
  endtask

  // Per-cycle comparison of both instances against the model queues.
  initial begin
    exp_t        e;
    logic        ev;
    logic [31:0] ed;
    logic        ee;
    forever begin
      @(negedge clk);
      ev = 1'b0; ed = 32'h0; ee = 1'b0;
      if (q1.size() > 0 && q1[0].due == cyc) begin
        e = q1.pop_front();
        ev = 1'b1; ed = e.d; ee = e.e;
      end
      n_chk++;
      if (rv1 !== ev || rd1 !== ed || re1 !== ee || rdy1 !== ready_exp) begin
        n_fail++;
        $display("FAIL rsp_lat1 cyc=%0d got v=%b d=%h e=%b rdy=%b exp v=%b d=%h e=%b rdy=%b",
                 cyc, rv1, rd1, re1, rdy1, ev, ed, ee, ready_exp);
      end
      ev = 1'b0; ed = 32'h0; ee = 1'b0;
      if (q3.size() > 0 && q3[0].due == cyc) begin
        e = q3.pop_front();
        ev = 1'b1; ed = e.d; ee = e.e;
      end
      n_chk++;
      if (rv3 !== ev || rd3 !== ed || re3 !== ee || rdy3 !== ready_exp) begin
        n_fail++;
        $display("FAIL rsp_lat3 cyc=%0d got v=%b d=%h e=%b rdy=%b exp v=%b d=%h e=%b rdy=%b",
                 cyc, rv3, rd3, re3, rdy3, ev, ed, ee, ready_exp);
      end
    end
  end

  initial begin
    for (int i = 0; i < 4096; i++) mdl[i] = 8'h00;

    // Reset for 3 cycles, then release.
    #1 rst = 1'b0;
    idle(3);
    release_reset();

    // Word store and load.
    req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "sw10");
    req(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "lw10");
    idle(4);

    // Byte store, sign/zero-extended byte loads.
    req(1'b1, 3'b000, 32'h13, 32'h80, 32'h0, 1'b0, "sb13");
    req(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, "lb13");
    req(1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0, "lbu13");
    req(1'b0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0, "lw10b");
    idle(2);

    // Halves, misalignment, illegal sizes, errored stores write nothing.
    req(1'b1, 3'b001, 32'h12, 32'h1234, 32'h0, 1'b0, "sh12");
    req(1'b0, 3'b101, 32'h12, 32'h0, 32'h00001234, 1'b0, "lhu12");
    req(1'b0, 3'b001, 32'h11, 32'h0, 32'h0, 1'b1, "lh11");
    req(1'b1, 3'b010, 32'h14, 32'h55AA55AA, 32'h0, 1'b0, "sw14");
    req(1'b1, 3'b010, 32'h16, 32'hFFFFFFFF, 32'h0, 1'b1, "sw16");
    req(1'b1, 3'b101, 32'h14, 32'hFFFFFFFF, 32'h0, 1'b1, "shu14");
    req(1'b0, 3'b010, 32'h14, 32'h0, 32'h55AA55AA, 1'b0, "lw14");
    req(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, "size011");
    req(1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0, "lh10");
    req(1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFBE, 1'b0, "lb11");
    req(1'b0, 3'b100, 32'h12, 32'h0, 32'h00000034, 1'b0, "lbu12");
    req(1'b0, 3'b010, 32'h10, 32'h0, 32'h1234BEEF, 1'b0, "lw10c");
    req(1'b1, 3'b000, 32'h15, 32'hFFFFFF7F, 32'h0, 1'b0, "sb15");
    req(1'b0, 3'b000, 32'h15, 32'h0, 32'h0000007F, 1'b0, "lb15");
    req(1'b0, 3'b010, 32'h14, 32'h0, 32'h55AA7FAA, 1'b0, "lw14b");
    idle(2);

    // Back-to-back loads across the range boundary.
    req(1'b1, 3'b010, 32'h4, 32'h11111111, 32'h0, 1'b0, "sw4");
    req(1'b1, 3'b010, 32'h8, 32'h22222222, 32'h0, 1'b0, "sw8");
    req(1'b1, 3'b010, 32'hC, 32'h83333333, 32'h0, 1'b0, "swc");
    req(1'b1, 3'b010, 32'hFFC, 32'hA5A5A5A5, 32'h0, 1'b0, "swffc");
    idle(1);
    req(1'b0, 3'b010, 32'h0, 32'h0, 32'h0, 1'b0, "lw0");
    req(1'b0, 3'b010, 32'h4, 32'h0, 32'h11111111, 1'b0, "lw4");
    req(1'b0, 3'b010, 32'h8, 32'h0, 32'h22222222, 1'b0, "lw8");
    req(1'b0, 3'b010, 32'hC, 32'h0, 32'h83333333, 1'b0, "lwc");
    req(1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b1, "lw1000");
    req(1'b0, 3'b010, 32'hFFC, 32'h0, 32'hA5A5A5A5, 1'b0, "lwffc");
    req(1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1, "lwhigh");
    idle(5);

    // Reset with responses in flight.
    req(1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0, "sw20");
    req(1'b0, 3'b010, 32'h4, 32'h0, 32'h11111111, 1'b0, "lw4b");
    req(1'b0, 3'b010, 32'h8, 32'h0, 32'h22222222, 1'b0, "lw8b");
    @(posedge clk);
    #1;
    check1("inflight_valid_u1", rv1, 1'b1);
    check1("inflight_valid_u3", rv3, 1'b1);
    req_valid = 1'b0;
    req_we    = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    check1("async_drop_u1", rv1, 1'b0);
    check1("async_drop_u3", rv3, 1'b0);
    check1("async_ready_u1", rdy1, 1'b0);
    q1.delete();
    q3.delete();
    ready_exp = 1'b0;
    idle(2);
    release_reset();
    idle(6);
    req(1'b0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, "lw20");
    req(1'b0, 3'b101, 32'h22, 32'h0, 32'h0000CAFE, 1'b0, "lhu22");
    req(1'b0, 3'b001, 32'h20, 32'h0, 32'hFFFFF00D, 1'b0, "lh20");
    idle(6);

    n_chk++;
    if (q1.size() != 0 || q3.size() != 0) begin
      n_fail++;
      $display("FAIL drain got q1=%0d q3=%0d exp 0 0", q1.size(), q3.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
